keypad_scan_matrix: RTL

Parametrised, debounced matrix-keypad scanner, the next generation of the team's 4x4 keypad reader. It drives one-hot row strobes at a divided scan rate, synchronises the column returns, and confirms a press only after it has been stable for a configurable number of scan ticks. On a confirmed press it emits a key index with a one-cycle strobe, holds a key-down level, and detects a debounced release. It sits between the keypad pins and the key-consuming logic (display/entry FSM).

---
 rtl/keypad_scan_matrix.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/keypad_scan_matrix.sv
// keypad_scan_matrix: debounced ROWS x COLS matrix keypad scanner.
// Define KEYPAD_RELEASE_EVT_EN to enable the one-cycle key_up release strobe.
module keypad_scan_matrix #(
   parameter int ROWS           = 4,
   parameter int COLS           = 4,
   parameter int SCAN_DIV       = 10000,
   parameter int DEBOUNCE_TICKS = 3,
   localparam int KW            = $clog2(ROWS*COLS)
) (
   input  logic            clock,
   input  logic            reset,
   output logic [ROWS-1:0] row,
   input  logic [COLS-1:0] col,
   output logic [KW-1:0]   key_code,
   output logic            data_ready,
   output logic            key_down,
   output logic            key_up
);

   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int DW = $clog2(SCAN_DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
   localparam logic [8:0]    DEB_CNT  = 9'(DEBOUNCE_TICKS);

   typedef enum logic [1:0] {
      SCAN,
      DEBOUNCE,
      HELD
   } state_t;

   state_t          state_q, state_d;
   logic [COLS-1:0] col_s1_q, col_s2_q;
   logic [DW-1:0]   div_q, div_d;
   logic [RW-1:0]   row_q, row_d;
   logic [RW-1:0]   cand_row_q, cand_row_d;
   logic [CW-1:0]   cand_col_q, cand_col_d;
   logic [7:0]      cnt_q, cnt_d;
   logic [KW-1:0]   key_code_q, key_code_d;
   logic            data_ready_q, data_ready_d;
   logic            key_down_q, key_down_d;
`ifdef KEYPAD_RELEASE_EVT_EN
   logic            key_up_q, key_up_d;
`endif

   logic            tick;
   logic [RW-1:0]   row_next;
   logic [CW-1:0]   low_col;
   logic            cand_bit;
   logic [8:0]      cnt_inc;
   logic            cnt_hit;

   assign tick     = (div_q == DIV_LAST);
   assign div_d    = tick ? '0 : div_q + DW'(1);
   assign row_next = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
   assign cand_bit = col_s2_q[cand_col_q];
   assign cnt_inc  = {1'b0, cnt_q} + 9'd1;
   assign cnt_hit  = (cnt_inc == DEB_CNT);

   // Descending scan so the lowest set column is the last one written.
   always_comb begin
      low_col = '0;
      for (int i = COLS - 1; i >= 0; i--) begin
         if (col_s2_q[i]) low_col = CW'(i);
      end
   end

   always_comb begin
      state_d      = state_q;
      row_d        = row_q;
      cand_row_d   = cand_row_q;
      cand_col_d   = cand_col_q;
      cnt_d        = cnt_q;
      key_code_d   = key_code_q;
      data_ready_d = 1'b0;
      key_down_d   = key_down_q;
`ifdef KEYPAD_RELEASE_EVT_EN
      key_up_d     = 1'b0;
`endif
      if (tick) begin
         unique case (state_q)
            SCAN: begin
               if (|col_s2_q) begin
                  cand_row_d = row_q;
                  cand_col_d = low_col;
                  cnt_d      = '0;
                  state_d    = DEBOUNCE;
               end else begin
                  row_d = row_next;
               end
            end
            DEBOUNCE: begin
               if (cand_bit) begin
                  if (cnt_hit) begin
                     key_code_d   = KW'(int'(cand_row_q) * COLS
                                        + int'(cand_col_q));
                     data_ready_d = 1'b1;
                     key_down_d   = 1'b1;
                     cnt_d        = '0;
                     state_d      = HELD;
                  end else begin
                     cnt_d = cnt_inc[7:0];
                  end
               end else begin
                  state_d = SCAN;
                  row_d   = row_next;
               end
            end
            HELD: begin
               if (!cand_bit) begin
                  if (cnt_hit) begin
                     key_down_d = 1'b0;
`ifdef KEYPAD_RELEASE_EVT_EN
                     key_up_d   = 1'b1;
`endif
                     cnt_d      = '0;
                     state_d    = SCAN;
                     row_d      = row_next;
                  end else begin
                     cnt_d = cnt_inc[7:0];
                  end
               end else begin
                  cnt_d = '0;
               end
            end
            default: state_d = SCAN;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         col_s1_q     <= '0;
         col_s2_q     <= '0;
         div_q        <= '0;
         state_q      <= SCAN;
         row_q        <= '0;
         cand_row_q   <= '0;
         cand_col_q   <= '0;
         cnt_q        <= '0;
         key_code_q   <= '0;
         data_ready_q <= 1'b0;
         key_down_q   <= 1'b0;
      end else begin
         col_s1_q     <= col;
         col_s2_q     <= col_s1_q;
         div_q        <= div_d;
         state_q      <= state_d;
         row_q        <= row_d;
         cand_row_q   <= cand_row_d;
         cand_col_q   <= cand_col_d;
         cnt_q        <= cnt_d;
         key_code_q   <= key_code_d;
         data_ready_q <= data_ready_d;
         key_down_q   <= key_down_d;
      end
   end

`ifdef KEYPAD_RELEASE_EVT_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) key_up_q <= 1'b0;
      else        key_up_q <= key_up_d;
   end
   assign key_up = key_up_q;
`else
   assign key_up = 1'b0;
`endif

   assign row        = ROWS'(1) << row_q;
   assign key_code   = key_code_q;
   assign data_ready = data_ready_q;
   assign key_down   = key_down_q;

endmodule
